ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares one single-port, synchronous-read data/instruction RAM between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage) of the five-stage pipeline CPU. It grants at most one access per cycle, favouring data accesses, with a starvation guard so fetch cannot be locked out. It returns read data one cycle after grant, tagged to the correct requester. It honours the pipeline `cancel` flush by discarding in-flight fetch responses.

## Interface
- `ADDR_W`, 8, RAM word-address width; the RAM index is taken from byte address bits `[ADDR_W+1:2]`.
- `STARVE_LIMIT`, 4, consecutive data grants allowed while a fetch waits before fetch wins once; legal range 1..15.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cancel` in 1: pipeline flush from WB; affects the fetch port only.
- `inst_req` in 1, `inst_addr` in 32: fetch read request; both held stable until granted.
- `inst_gnt` out 1: fetch accepted this cycle.
- `inst_rvalid` out 1, `inst_rdata` out 32: fetch response.
- `data_req` in 1, `data_addr` in 32, `data_wen` in 4, `data_wdata` in 32: data request; `data_wen==0` is a read, any nonzero is a byte-enable write; held until granted.
- `data_gnt` out 1: data request accepted this cycle.
- `data_rvalid` out 1, `data_rdata` out 32: data read response.
- `ram_en` out 1, `ram_wen` out 4, `ram_addr` out ADDR_W, `ram_wdata` out 32: RAM command.
- `ram_rdata` in 32: RAM read data, valid the cycle after an enabled read.

## Operation
- Grant is combinational in cycle T from the requests, `cancel` and the starvation state. Exactly one of `inst_gnt`/`data_gnt` is high per cycle, or neither.
- Priority:
  - If only one requester is active, it is granted.
  - If both are active, data wins, unless `starve_cnt == STARVE_LIMIT`; then fetch wins.
- The starvation counter `starve_cnt` (4 bits):
  - increments on each cycle where `data_gnt & inst_req`;
  - clears on `inst_gnt` or when `inst_req` is low;
  - saturates at `STARVE_LIMIT`.
- `cancel` high in cycle T:
  - forces `inst_gnt=0` in T;
  - clears any pending fetch response tag, so `inst_rvalid` is 0 in T+1.
  - The data port proceeds normally.
- RAM command in grant cycle:
  - `ram_en=1`; `ram_addr` is the granted address bits `[ADDR_W+1:2]`; bits `[1:0]` are ignored.
  - For a data grant: `ram_wen=data_wen`, `ram_wdata=data_wdata`.
  - For a fetch grant: `ram_wen=0`.
- Response tag register:
  - `{pend_inst, pend_data}` is set in T for a granted read (fetch, or data with `wen==0`).
  - Writes set no tag and produce no `data_rvalid`.
- Responses:
  - `inst_rvalid`/`data_rvalid` equal the respective tag in T+1.
  - Both `*_rdata` are driven from `ram_rdata` unconditionally; consumers qualify with `rvalid`.
- Throughput: one access per cycle. A new grant in T+1 coexists with the response from T.
- Reset state:
  - tags 0, `starve_cnt` 0;
  - `inst_gnt`, `data_gnt`, `ram_en`, `ram_wen`, `inst_rvalid`, `data_rvalid` all 0 while `reset` is high.
  - A grant coinciding with a `reset` cycle is squashed; its response never appears.

## Timing
- Grant latency: 0 cycles (same cycle as request, if it wins).
- Read latency: grant in T → `*_rvalid` plus data in T+1, for one cycle, no backpressure.
- Write: committed at the edge ending T; a read of the same address granted in T+1 returns the new data in T+2.
- Simultaneous `cancel` and both requests in T: data is granted and fetch is blocked; `starve_cnt` increments.
- Simultaneous `cancel` in T with a fetch granted in T−1: `inst_rvalid` is suppressed in T. Required because the flushed fetch must not reach ID.
- Worst-case fetch wait with continuous data traffic: `STARVE_LIMIT` cycles, then granted.
- `reset` mid-response (reset in T, grant in T−1): `*_rvalid` is 0 in T.

## Structure
- Shared package `cpu_mem_pkg` holds:
  - `ADDR_W` and `STARVE_LIMIT` defaults;
  - port-id constants `PORT_INST=0`, `PORT_DATA=1`;
  - the `wen` width constant (4).
- One sub-module, `ram_arb_prio`:
  - contains the combinational priority/grant logic plus the starvation counter;
  - inputs are the requests, `cancel` and `reset`; outputs are the two grants.
- The top level holds the command mux, the tag register and the response steering.

## Test plan
- Fetch only, addr 0x10, 0x14, 0x18 back-to-back:
  - `inst_gnt` is high each cycle;
  - `inst_rvalid` follows one cycle later with RAM words 4, 5, 6;
  - `data_rvalid` stays 0.
- Data write `wen=4'hF` addr 0x20 data 0xDEADBEEF, then data read 0x20:
  - no `rvalid` after the write;
  - `data_rvalid=1`, `data_rdata=0xDEADBEEF` two cycles after the write grant.
- Both requests held continuously, `STARVE_LIMIT=4`:
  - data granted 4 cycles, then fetch 1 cycle, repeating;
  - fetch never waits more than 4 cycles.
- Fetch granted in T, `cancel` in T+1 with `inst_req` high:
  - `inst_rvalid=0` in T+1;
  - `inst_gnt=0` in T+1;
  - fetch granted in T+2 after `cancel` drops.
- Byte write `wen=4'b0010` data 0x0000AB00 to a word holding 0x11223344, then read:
  - returns 0x1122AB44.
- `reset` asserted in the cycle after a data read grant:
  - `data_rvalid=0`, all grants 0 during reset;
  - `starve_cnt` restarts from 0 afterwards.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU memory subsystem: default geometry,
// requester port ids and command field widths.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEFAULT       = 8;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  localparam int unsigned PORT_INST = 0;
  localparam int unsigned PORT_DATA = 1;

  localparam int unsigned WEN_W  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

endpackage

// File: rtl/ram_arb_prio.sv
// Fetch/data grant arbitration: data first, with a starvation counter that
// lets a waiting fetch win once after STARVE_LIMIT consecutive data grants.
module ram_arb_prio
  import cpu_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic cancel,
  input  logic inst_req,
  input  logic data_req,
  output logic inst_gnt,
  output logic data_gnt
);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             inst_ok;
  logic             data_ok;
  logic             fetch_due;

  always_comb begin
    inst_ok   = inst_req & ~cancel & ~reset;
    data_ok   = data_req & ~reset;
    fetch_due = (starve_cnt == CNT_W'(STARVE_LIMIT));
    inst_gnt  = inst_ok & (~data_ok | fetch_due);
    data_gnt  = data_ok & ~inst_gnt;

    // Count data grants that overtook a waiting fetch; saturate at the limit.
    starve_nxt = starve_cnt;
    if (inst_gnt || !inst_req) begin
      starve_nxt = '0;
    end else if (data_gnt && !fetch_due) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read RAM between the fetch and data ports: one
// access per cycle, read data returned one cycle later to the right port.
module ram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEFAULT,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic [31:0]       data_addr,
  input  logic [WEN_W-1:0]  data_wen,
  input  logic [31:0]       data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,
  output logic              ram_en,
  output logic [WEN_W-1:0]  ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic port_sel;
  logic pend_inst;
  logic pend_data;
  logic unused_addr_bits;

  ram_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk     (clk),
    .reset   (reset),
    .cancel  (cancel),
    .inst_req(inst_req),
    .data_req(data_req),
    .inst_gnt(inst_gnt),
    .data_gnt(data_gnt)
  );

  assign port_sel = data_gnt ? 1'(PORT_DATA) : 1'(PORT_INST);

  // RAM command driven from whichever port won this cycle.
  always_comb begin
    ram_en    = inst_gnt | data_gnt;
    ram_wen   = '0;
    ram_addr  = inst_addr[ADDR_W+1:2];
    ram_wdata = data_wdata;
    if (port_sel == 1'(PORT_DATA)) begin
      ram_addr = data_addr[ADDR_W+1:2];
      ram_wen  = data_wen;
    end
  end

  // Response tags: which port owns the read data arriving next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_inst <= 1'b0;
      pend_data <= 1'b0;
    end else begin
      pend_inst <= inst_gnt;
      pend_data <= data_gnt & (data_wen == '0);
    end
  end

  // A flush in the response cycle kills a fetch that was already in flight.
  assign inst_rvalid = pend_inst & ~cancel & ~reset;
  assign data_rvalid = pend_data & ~reset;
  assign inst_rdata  = ram_rdata;
  assign data_rdata  = ram_rdata;

  assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                              data_addr[31:ADDR_W+2], data_addr[1:0]};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios then random
// traffic, checked against a behavioural arbitration and memory model.
module tb_ram_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        cancel;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic [3:0]  data_wen;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  ram_port_arbiter #(.ADDR_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .cancel(cancel),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_wen(data_wen),
    .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: unwritten words read back as their own index.
  logic [31:0] ram_mem [256];
  logic        ram_wr  [256];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : 32'(ram_addr);
      if (ram_wen != 4'h0) begin
        ram_mem[ram_addr] <= merge(ram_wr[ram_addr] ? ram_mem[ram_addr] : 32'(ram_addr),
                                   ram_wdata, ram_wen);
        ram_wr[ram_addr]  <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       inst_q[$];
  resp_t       data_q[$];
  logic [31:0] ref_mem [256];
  int          m_wait;
  int          checks = 0;
  int          passes = 0;
  bit          track = 1'b0;
  int          wait_run = 0;
  int          max_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // One bus cycle: apply inputs, predict grants at the falling edge, queue responses.
  task automatic drive_cycle(input logic ir, input logic [31:0] ia, input logic dr,
                             input logic [31:0] da, input logic [3:0] dw,
                             input logic [31:0] dd, input logic cn, input logic rs,
                             output logic gi, output logic gd);
    logic ok_i, ok_d;
    resp_t r;
    inst_req = ir; inst_addr = ia; data_req = dr; data_addr = da;
    data_wen = dw; data_wdata = dd; cancel = cn; reset = rs;
    @(negedge clk);
    ok_i = ir && !cn && !rs;
    ok_d = dr && !rs;
    // Data goes first unless fetch has already been passed over LIMIT times.
    gi = ok_i && (!ok_d || m_wait >= int'(LIMIT));
    gd = ok_d && !gi;
    chk("inst_gnt", 32'(inst_gnt), 32'(gi));
    chk("data_gnt", 32'(data_gnt), 32'(gd));
    chk("ram_en", 32'(ram_en), 32'(gi || gd));
    if (gi) begin
      chk("ram_addr_inst", 32'(ram_addr), 32'(ia[9:2]));
      chk("ram_wen_inst", 32'(ram_wen), 32'h0);
      r.due = cyc + 1; r.data = ref_mem[ia[9:2]];
      inst_q.push_back(r);
    end
    if (gd) begin
      chk("ram_addr_data", 32'(ram_addr), 32'(da[9:2]));
      chk("ram_wen_data", 32'(ram_wen), 32'(dw));
      if (dw == 4'h0) begin
        r.due = cyc + 1; r.data = ref_mem[da[9:2]];
        data_q.push_back(r);
      end else begin
        chk("ram_wdata", ram_wdata, dd);
        ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], dd, dw);
      end
    end
    if (rs || gi || !ir) m_wait = 0;
    else if (gd) m_wait = m_wait + 1;
    if (track) begin
      if (inst_req && !inst_gnt) wait_run++;
      else wait_run = 0;
      if (wait_run > max_wait) max_wait = wait_run;
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the entry due this cycle, unless flushed or reset.
  always @(negedge clk) begin : mon
    resp_t r;
    logic  ev;
    ev = 1'b0;
    if (inst_q.size() > 0 && inst_q[0].due == cyc) begin
      r  = inst_q.pop_front();
      ev = !cancel && !reset;
    end
    chk("inst_rvalid", 32'(inst_rvalid), 32'(ev));
    if (ev) chk("inst_rdata", inst_rdata, r.data);
    ev = 1'b0;
    if (data_q.size() > 0 && data_q[0].due == cyc) begin
      r  = data_q.pop_front();
      ev = !reset;
    end
    chk("data_rvalid", 32'(data_rvalid), 32'(ev));
    if (ev) chk("data_rdata", data_rdata, r.data);
  end

  initial begin
    logic        gi, gd;
    logic        ip, dp, cn, rs;
    logic [31:0] ia, da, dd;
    logic [3:0]  dw;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
    m_wait = 0;

    // Reset with both requests high: everything squashed.
    for (int i = 0; i < 3; i++) drive_cycle(1, 32'h10, 1, 32'h20, 4'h0, 0, 0, 1, gi, gd);

    // Back-to-back fetches of words 4, 5, 6.
    drive_cycle(1, 32'h10, 0, 0, 4'h0, 0, 0, 0, gi, gd);
    drive_cycle(1, 32'h14, 0, 0, 4'h0, 0, 0, 0, gi, gd);
    drive_cycle(1, 32'h18, 0, 0, 4'h0, 0, 0, 0, gi, gd);
    drive_cycle(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd);

    // Full-word write then read-back of the same word.
    drive_cycle(0, 0, 1, 32'h20, 4'hF, 32'hDEADBEEF, 0, 0, gi, gd);
    drive_cycle(0, 0, 1, 32'h23, 4'h0, 0, 0, 0, gi, gd);
    drive_cycle(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd);

    // Both requesters held: data wins LIMIT times, then fetch once.
    track = 1'b1;
    for (int i = 0; i < 16; i++) drive_cycle(1, 32'h30, 1, 32'h40, 4'h0, 0, 0, 0, gi, gd);
    track = 1'b0;
    drive_cycle(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd);

    // Fetch granted, then flushed in the response cycle, then retried.
    drive_cycle(1, 32'h30, 0, 0, 4'h0, 0, 0, 0, gi, gd);
    drive_cycle(1, 32'h34, 0, 0, 4'h0, 0, 1, 0, gi, gd);
    drive_cycle(1, 32'h34, 0, 0, 4'h0, 0, 0, 0, gi, gd);
    drive_cycle(1, 32'h38, 1, 32'h44, 4'h0, 0, 1, 0, gi, gd);
    drive_cycle(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd);

    // Single-byte merge into an existing word.
    drive_cycle(0, 0, 1, 32'h50, 4'hF, 32'h11223344, 0, 0, gi, gd);
    drive_cycle(0, 0, 1, 32'h50, 4'b0010, 32'h0000AB00, 0, 0, gi, gd);
    drive_cycle(0, 0, 1, 32'h50, 4'h0, 0, 0, 0, gi, gd);
    drive_cycle(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd);

    // Reset right after a data read grant, then starvation restarts from zero.
    drive_cycle(0, 0, 1, 32'h50, 4'h0, 0, 0, 0, gi, gd);
    drive_cycle(1, 32'h60, 1, 32'h64, 4'h0, 0, 0, 1, gi, gd);
    drive_cycle(1, 32'h60, 1, 32'h64, 4'h0, 0, 0, 1, gi, gd);
    for (int i = 0; i < 6; i++) drive_cycle(1, 32'h60, 1, 32'h64, 4'h0, 0, 0, 0, gi, gd);
    drive_cycle(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd);

    // Random traffic; each request holds until granted.
    ip = 0; dp = 0; ia = 0; da = 0; dd = 0; dw = 0;
    for (int i = 0; i < 600; i++) begin
      if (!ip && ($urandom % 3 != 0)) begin ip = 1; ia = $urandom; end
      if (!dp && ($urandom % 2 == 0)) begin
        dp = 1; da = $urandom; dd = $urandom;
        case ($urandom % 4)
          0, 1:    dw = 4'h0;
          2:       dw = 4'hF;
          default: dw = 4'($urandom);
        endcase
      end
      cn = ($urandom % 8 == 0);
      rs = ($urandom % 64 == 0);
      drive_cycle(ip, ia, dp, da, dw, dd, cn, rs, gi, gd);
      if (gi) ip = 0;
      if (gd) dp = 0;
    end

    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd);
    chk("max_fetch_wait_le_limit", 32'(max_wait <= int'(LIMIT)), 32'h1);
    chk("starve_wait_reached", 32'(max_wait), 32'(LIMIT));
    chk("queues_drained", 32'(inst_q.size() + data_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
